// File: rtl/dma_stream_fifo.sv
// First-word-fall-through stream buffer between the DMA data source and its consumer.
// Optional sticky overflow flag output enabled by defining FIFO_OVF_FLAG_EN.
module dma_stream_fifo #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic              fifo_valid,
    input  logic              fifo_ready,
    output logic [DATA_W-1:0] fifo_data,
    output logic [ADDR_W:0]   level,
`ifdef FIFO_OVF_FLAG_EN
    output logic              ovf,
`endif
    output logic [31:0]       wr_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] THRESH_L = AFULL_THRESH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;

    assign full        = (level == DEPTH_L);
    assign almost_full = (level >= THRESH_L);
    assign fifo_valid  = (level != '0);
    assign fifo_data   = mem[rd_ptr];

    // Flags come from the pre-edge level, so a full buffer drops a write
    // even when the head is popped in the same cycle.
    assign push = wr_en && !full && !flush;
    assign pop  = fifo_valid && fifo_ready && !flush;

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_cnt <= '0;
        end else if (push) begin
            wr_cnt <= wr_cnt + 32'd1;
        end
    end

`ifdef FIFO_OVF_FLAG_EN
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full && !flush) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_stream_fifo.sv
// Directed testbench for dma_stream_fifo with immediate-assertion checks.
// Covers reset, FWFT ordering, full/almost_full, drop-on-full, wrap, flush and async reset.
module tb_dma_stream_fifo;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic        almost_full;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [31:0] fifo_data;
    logic [4:0]  level;
    logic [31:0] wr_cnt;
`ifdef FIFO_OVF_FLAG_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_cnt;

    always #5 sys_clk = ~sys_clk;

    dma_stream_fifo dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .fifo_valid  (fifo_valid),
        .fifo_ready  (fifo_ready),
        .fifo_data   (fifo_data),
        .level       (level),
`ifdef FIFO_OVF_FLAG_EN
        .ovf         (ovf),
`endif
        .wr_cnt      (wr_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rst    = 1'b0;
        flush      = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        fifo_ready = 1'b0;
        exp_cnt    = '0;

        // T1 reset then idle
        repeat (3) tick();
        chk("t1_valid", 64'(fifo_valid), 64'd0);
        chk("t1_level", 64'(level), 64'd0);
        chk("t1_wr_cnt", 64'(wr_cnt), 64'd0);
        chk("t1_full", 64'(full), 64'd0);
        chk("t1_afull", 64'(almost_full), 64'd0);
`ifdef FIFO_OVF_FLAG_EN
        chk("t1_ovf", 64'(ovf), 64'd0);
`endif
        sys_rst = 1'b1;
        tick();
        chk("t1_idle_level", 64'(level), 64'd0);

        // T2 five words held, then drained in order
        for (int i = 1; i <= 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'(i);
            tick();
            exp_cnt = exp_cnt + 32'd1;
            if (i == 1) begin
                chk("t2_first_valid", 64'(fifo_valid), 64'd1);
                chk("t2_first_data", 64'(fifo_data), 64'd1);
            end
        end
        wr_en = 1'b0;
        chk("t2_level5", 64'(level), 64'd5);
        chk("t2_head", 64'(fifo_data), 64'd1);
        tick();
        chk("t2_head_held", 64'(fifo_data), 64'd1);
        chk("t2_level_held", 64'(level), 64'd5);
        fifo_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("t2_pop_data", 64'(fifo_data), 64'(i));
            tick();
        end
        fifo_ready = 1'b0;
        chk("t2_level0", 64'(level), 64'd0);
        chk("t2_valid0", 64'(fifo_valid), 64'd0);
        chk("t2_wr_cnt", 64'(wr_cnt), 64'(exp_cnt));
        fifo_ready = 1'b1;
        tick();
        chk("t2_empty_pop_level", 64'(level), 64'd0);
        fifo_ready = 1'b0;

        // T3 fill past full with no consumer
        for (int i = 1; i <= 20; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h100 + 32'(i - 1);
            tick();
            if (i <= 16) exp_cnt = exp_cnt + 32'd1;
            if (i == 11) chk("t3_afull_11", 64'(almost_full), 64'd0);
            if (i == 12) chk("t3_afull_12", 64'(almost_full), 64'd1);
            if (i == 15) chk("t3_full_15", 64'(full), 64'd0);
            if (i == 16) chk("t3_full_16", 64'(full), 64'd1);
`ifdef FIFO_OVF_FLAG_EN
            if (i == 16) chk("t3_ovf_16", 64'(ovf), 64'd0);
            if (i == 17) chk("t3_ovf_17", 64'(ovf), 64'd1);
`endif
        end
        wr_en = 1'b0;
        chk("t3_level16", 64'(level), 64'd16);
        chk("t3_wr_cnt", 64'(wr_cnt), 64'(exp_cnt));
        chk("t3_head", 64'(fifo_data), 64'h100);

        // T4 full with simultaneous write and pop
        wr_en      = 1'b1;
        wr_data    = 32'hDEAD_BEEF;
        fifo_ready = 1'b1;
        tick();
        chk("t4_level15", 64'(level), 64'd15);
        chk("t4_wr_cnt_same", 64'(wr_cnt), 64'(exp_cnt));
        chk("t4_head", 64'(fifo_data), 64'h101);
        tick();
        exp_cnt = exp_cnt + 32'd1;
        chk("t4_level15_again", 64'(level), 64'd15);
        chk("t4_wr_cnt_inc", 64'(wr_cnt), 64'(exp_cnt));
        wr_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i < 14) chk("t4_drain", 64'(fifo_data), 64'(32'h102 + 32'(i)));
            else        chk("t4_drain_last", 64'(fifo_data), 64'hDEAD_BEEF);
            tick();
        end
        chk("t4_level0", 64'(level), 64'd0);
        fifo_ready = 1'b0;

        // T5 wrap with consumer always ready
        fifo_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wr_en   = 1'b1;
            wr_data = 32'hC000_0000 + 32'(k * 3);
            tick();
            exp_cnt = exp_cnt + 32'd1;
            chk("t5_data", 64'(fifo_data), 64'(32'hC000_0000 + 32'(k * 3)));
            chk("t5_level1", 64'(level), 64'd1);
        end
        wr_en = 1'b0;
        tick();
        chk("t5_level0", 64'(level), 64'd0);
        chk("t5_wr_cnt", 64'(wr_cnt), 64'(exp_cnt));
        fifo_ready = 1'b0;

        // T6 flush clears pointers but keeps the write count
        for (int i = 0; i < 7; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h600 + 32'(i);
            tick();
            exp_cnt = exp_cnt + 32'd1;
        end
        wr_en = 1'b0;
        chk("t6_level7", 64'(level), 64'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_flush_level", 64'(level), 64'd0);
        chk("t6_flush_valid", 64'(fifo_valid), 64'd0);
        chk("t6_flush_wr_cnt", 64'(wr_cnt), 64'(exp_cnt));
`ifdef FIFO_OVF_FLAG_EN
        chk("t6_ovf_kept", 64'(ovf), 64'd1);
`endif
        wr_en   = 1'b1;
        wr_data = 32'hA5A5_A5A5;
        tick();
        wr_en = 1'b0;
        chk("t6_data", 64'(fifo_data), 64'hA5A5_A5A5);
        chk("t6_level1", 64'(level), 64'd1);

        // Asynchronous reset mid-stream, between clock edges
        #2;
        sys_rst = 1'b0;
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(fifo_valid), 64'd0);
        chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
`ifdef FIFO_OVF_FLAG_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        tick();
        sys_rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
